// File: rtl/os_sa_pkg.sv
`default_nettype none
// ============================================================================
// os_sa_pkg : shared types and helpers for the output-stationary systolic array
// Rev 1.0
// ============================================================================
package os_sa_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } sa_state_e;

  // Working width for the saturating adder; accumulators must be narrower.
  localparam int SA_WIDE_W = 64;

  // Ceiling log2 with a floor of 1 so single-entry indices still get a bit.
  function automatic int sa_clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  // Signed add clamped to the range of a 'width'-bit two's-complement value.
  function automatic logic signed [SA_WIDE_W-1:0] sa_sat_add(
    input logic signed [SA_WIDE_W-1:0] a,
    input logic signed [SA_WIDE_W-1:0] b,
    input int                          width
  );
    logic signed [SA_WIDE_W-1:0] sum;
    logic signed [SA_WIDE_W-1:0] hi;
    logic signed [SA_WIDE_W-1:0] lo;
    sum = a + b;
    hi  = (SA_WIDE_W'(1) <<< (width - 1)) - SA_WIDE_W'(1);
    lo  = -hi - SA_WIDE_W'(1);
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/os_pe.sv
`default_nettype none
// ============================================================================
// os_pe : one processing element - operand pass-through registers plus MAC.
// SA_SATURATE_EN selects a saturating accumulator. Rev 1.0
// ============================================================================
module os_pe
  import os_sa_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ACC_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic [WORD_SIZE-1:0] a_o,
  output logic [WORD_SIZE-1:0] b_o,
  output logic [ACC_SIZE-1:0]  acc_out
);

  logic signed [WORD_SIZE-1:0]   a_q;
  logic signed [WORD_SIZE-1:0]   b_q;
  logic signed [2*WORD_SIZE-1:0] prod;
  logic signed [ACC_SIZE-1:0]    prod_ext;
  logic signed [ACC_SIZE-1:0]    acc_q;
  logic signed [ACC_SIZE-1:0]    acc_d;

  // The MAC works on the registered operands, so a beat reaches PE(r,c)
  // r+c+1 cycles after it is accepted.
  assign prod     = a_q * b_q;
  assign prod_ext = ACC_SIZE'(prod);

`ifdef SA_SATURATE_EN
  assign acc_d = ACC_SIZE'(sa_sat_add(SA_WIDE_W'(acc_q), SA_WIDE_W'(prod_ext), ACC_SIZE));
`else
  assign acc_d = acc_q + prod_ext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clear_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (en_i) acc_q <= acc_d;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign acc_out = acc_q;

endmodule
`default_nettype wire

// File: rtl/os_systolic_array.sv
`default_nettype none
// ============================================================================
// os_systolic_array : output-stationary ROWS x COLS MAC array with internal
// operand skew, flush and row-by-row drain. SA_SATURATE_EN: saturating acc.
// Rev 1.0
// ============================================================================
module os_systolic_array
  import os_sa_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 8,
  parameter int ACC_SIZE  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [ROWS*WORD_SIZE-1:0] left_in_bus,
  input  logic [COLS*WORD_SIZE-1:0] top_in_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [sa_clog2(ROWS)-1:0] out_row_idx,
  output logic [COLS*ACC_SIZE-1:0]  out_bus,
  output logic                      busy
);

  localparam int                IDX_W     = sa_clog2(ROWS);
  localparam int                FLUSH_N   = ROWS + COLS;
  localparam int                FCNT_W    = sa_clog2(FLUSH_N);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_N - 1);
  localparam logic [IDX_W-1:0]  ROW_LAST  = IDX_W'(ROWS - 1);

  sa_state_e                state_q, state_d;
  logic [FCNT_W-1:0]        fcnt_q, fcnt_d;
  logic [IDX_W-1:0]         row_q, row_d;
  logic [COLS*ACC_SIZE-1:0] obus_q, obus_d;
  logic                     accept, out_hs, last_hs, flush_done, mac_en;
  logic [IDX_W-1:0]         mux_sel;
  logic [COLS*ACC_SIZE-1:0] mux_row;

  logic [WORD_SIZE-1:0]     a_h   [ROWS][COLS+1];
  logic [WORD_SIZE-1:0]     b_v   [ROWS+1][COLS];
  logic [ACC_SIZE-1:0]      acc_pe[ROWS][COLS];

  assign in_ready    = (state_q == IDLE) || (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DRAIN);
  assign out_last    = out_valid && (row_q == ROW_LAST);
  assign out_row_idx = row_q;
  assign out_bus     = obus_q;

  assign accept     = in_valid && in_ready;
  assign out_hs     = out_valid && out_ready;
  assign last_hs    = out_hs && (row_q == ROW_LAST);
  assign flush_done = (state_q == FLUSH) && (fcnt_q == FCNT_LAST);
  assign mac_en     = (state_q == LOAD) || (state_q == FLUSH);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = in_last ? FLUSH : LOAD;
          fcnt_d  = '0;
        end
      end
      LOAD: begin
        if (accept && in_last) begin
          state_d = FLUSH;
          fcnt_d  = '0;
        end
      end
      FLUSH: begin
        if (flush_done) begin
          state_d = DRAIN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row 0 is preloaded on the last flush cycle so out_bus is valid as soon
  // as out_valid rises; later rows load on each accepted handshake.
  assign mux_sel = flush_done ? '0 : row_q + 1'b1;

  always_comb begin
    mux_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (mux_sel == IDX_W'(r)) begin
        for (int c = 0; c < COLS; c++) mux_row[c*ACC_SIZE +: ACC_SIZE] = acc_pe[r][c];
      end
    end
  end

  always_comb begin
    row_d  = row_q;
    obus_d = obus_q;
    if (flush_done) begin
      row_d  = '0;
      obus_d = mux_row;
    end else if (last_hs) begin
      row_d  = '0;
      obus_d = '0;
    end else if (out_hs) begin
      row_d  = mux_sel;
      obus_d = mux_row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      row_q   <= '0;
      obus_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      row_q   <= row_d;
      obus_q  <= obus_d;
    end
  end

  // Edge skew: row r is delayed r cycles; idle cycles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic [WORD_SIZE-1:0] a_inj;
    assign a_inj = accept ? left_in_bus[(r+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
    if (r == 0) begin : g_direct
      assign a_h[r][0] = a_inj;
    end else begin : g_delay
      logic [WORD_SIZE-1:0] sk_q [r];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else if (last_hs) begin
          for (int i = 0; i < r; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= a_inj;
          for (int i = 1; i < r; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign a_h[r][0] = sk_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic [WORD_SIZE-1:0] b_inj;
    assign b_inj = accept ? top_in_bus[(c+1)*WORD_SIZE-1 -: WORD_SIZE] : '0;
    if (c == 0) begin : g_direct
      assign b_v[0][c] = b_inj;
    end else begin : g_delay
      logic [WORD_SIZE-1:0] sk_q [c];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < c; i++) sk_q[i] <= '0;
        end else if (last_hs) begin
          for (int i = 0; i < c; i++) sk_q[i] <= '0;
        end else begin
          sk_q[0] <= b_inj;
          for (int i = 1; i < c; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign b_v[0][c] = sk_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      os_pe #(
        .WORD_SIZE (WORD_SIZE),
        .ACC_SIZE  (ACC_SIZE)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .clear_i (last_hs),
        .en_i    (mac_en),
        .a_i     (a_h[r][c]),
        .b_i     (b_v[r][c]),
        .a_o     (a_h[r][c+1]),
        .b_o     (b_v[r+1][c]),
        .acc_out (acc_pe[r][c])
      );
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_os_systolic_array.sv
`default_nettype none
// ============================================================================
// tb_os_systolic_array : randomized jobs against a matrix-product model.
// Rev 1.0
// ============================================================================
module tb_os_systolic_array;

  localparam int ROWS      = 3;
  localparam int COLS      = 4;
  localparam int WORD_SIZE = 8;
  localparam int ACC_SIZE  = 16;
  localparam int IDX_W     = 2;
  localparam int MAXK      = 16;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic                      in_last = 1'b0;
  logic [ROWS*WORD_SIZE-1:0] left_in_bus = '0;
  logic [COLS*WORD_SIZE-1:0] top_in_bus = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic                      out_last;
  logic [IDX_W-1:0]          out_row_idx;
  logic [COLS*ACC_SIZE-1:0]  out_bus;
  logic                      busy;

  int     total = 0;
  int     bad   = 0;
  int     a_m   [MAXK][ROWS];
  int     b_m   [MAXK][COLS];
  longint exp_c [ROWS][COLS];

  os_systolic_array #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WORD_SIZE (WORD_SIZE),
    .ACC_SIZE  (ACC_SIZE)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .left_in_bus (left_in_bus),
    .top_in_bus  (top_in_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_row_idx (out_row_idx),
    .out_bus     (out_bus),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One accumulation step in ACC_SIZE-bit arithmetic.
  function automatic longint acc_step(input longint acc, input longint p);
    longint s;
    longint hi;
    longint lo;
    s  = acc + p;
    hi = (longint'(1) <<< (ACC_SIZE - 1)) - 1;
    lo = -hi - 1;
`ifdef SA_SATURATE_EN
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`else
    s = s & ((longint'(1) <<< ACC_SIZE) - 1);
    if (s > hi) s = s - (longint'(1) <<< ACC_SIZE);
`endif
    return s;
  endfunction

  task automatic compute_expected(input int k_len);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        exp_c[r][c] = 0;
        for (int k = 0; k < k_len; k++)
          exp_c[r][c] = acc_step(exp_c[r][c], longint'(a_m[k][r]) * longint'(b_m[k][c]));
      end
  endtask

  task automatic fill_random(input int k_len);
    for (int k = 0; k < k_len; k++) begin
      for (int r = 0; r < ROWS; r++) a_m[k][r] = int'($urandom_range(0, 255)) - 128;
      for (int c = 0; c < COLS; c++) b_m[k][c] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic fill_const(input int k_len, input int va, input int vb);
    for (int k = 0; k < k_len; k++) begin
      for (int r = 0; r < ROWS; r++) a_m[k][r] = va;
      for (int c = 0; c < COLS; c++) b_m[k][c] = vb;
    end
  endtask

  task automatic check_reset(input string p);
    check_val({p, "_in_ready"}, in_ready, 1);
    check_val({p, "_out_valid"}, out_valid, 0);
    check_val({p, "_out_last"}, out_last, 0);
    check_val({p, "_row_idx"}, out_row_idx, 0);
    check_val({p, "_out_bus_zero"}, (out_bus == '0) ? 1 : 0, 1);
    check_val({p, "_busy"}, busy, 0);
  endtask

  task automatic pulse_reset();
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset("async_rst");
    @(negedge clk);
    check_reset("hold_rst");
    rst = 1'b1;
  endtask

  // rdy_mode: 0 always ready, 1 toggle 1/0, 2 random. abort_row >= 0 resets
  // the DUT when that row is on the bus.
  task automatic run_job(input int k_len, input int bubble_pct, input int rdy_mode,
                         input int abort_row);
    int k;
    int guard;
    int waitc;
    int e;
    bit stalled;
    logic [COLS*ACC_SIZE-1:0] held;
    compute_expected(k_len);
    k     = 0;
    guard = 0;
    while (k < k_len && guard < 1000) begin
      @(negedge clk);
      guard++;
      check_val("in_ready_load", in_ready, 1);
      if (int'($urandom_range(0, 99)) < bubble_pct) begin
        in_valid    = 1'b0;
        in_last     = 1'($urandom_range(0, 1));
        left_in_bus = (ROWS*WORD_SIZE)'($urandom);
        top_in_bus  = (COLS*WORD_SIZE)'($urandom);
      end else begin
        in_valid = 1'b1;
        in_last  = (k == k_len - 1);
        for (int r = 0; r < ROWS; r++) left_in_bus[r*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(a_m[k][r]);
        for (int c = 0; c < COLS; c++) top_in_bus[c*WORD_SIZE +: WORD_SIZE] = WORD_SIZE'(b_m[k][c]);
        k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    waitc    = 1;
    while (!out_valid && waitc < 40) begin
      check_val("in_ready_flush", in_ready, 0);
      check_val("busy_flush", busy, 1);
      @(negedge clk);
      waitc++;
    end
    check_val("first_valid_latency", waitc, ROWS + COLS + 1);
    e       = 0;
    stalled = 1'b0;
    held    = '0;
    guard   = 0;
    while (e < ROWS && guard < 200) begin
      check_val("out_valid_drain", out_valid, 1);
      check_val("row_idx", out_row_idx, e);
      check_val("out_last", out_last, (e == ROWS - 1) ? 1 : 0);
      check_val("in_ready_drain", in_ready, 0);
      if (stalled) check_val("stall_hold", (out_bus == held) ? 1 : 0, 1);
      if (e == abort_row) begin
        pulse_reset();
        return;
      end
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (guard % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_ready) begin
        for (int c = 0; c < COLS; c++)
          check_val($sformatf("c_r%0d_c%0d", e, c),
                    longint'($signed(out_bus[c*ACC_SIZE +: ACC_SIZE])), exp_c[e][c]);
        e++;
        stalled = 1'b0;
      end else begin
        held    = out_bus;
        stalled = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    check_val("drain_done_rows", e, ROWS);
    out_ready = 1'b0;
    check_val("idle_out_valid", out_valid, 0);
    check_val("idle_in_ready", in_ready, 1);
    check_val("idle_busy", busy, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;

    // Identity-style B: C rows pick out A's first two columns.
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < ROWS; r++) a_m[k][r] = k * ROWS + r + 1;
      for (int c = 0; c < COLS; c++) b_m[k][c] = (c == k) ? 1 : 0;
    end
    run_job(2, 0, 0, -1);

    fill_const(8, -128, -128);
    run_job(8, 0, 0, -1);
    run_job(8, 50, 0, -1);

    fill_const(3, 127, 127);
    run_job(3, 0, 0, -1);

    fill_random(5);
    run_job(5, 0, 1, -1);

    fill_random(4);
    run_job(4, 20, 0, 1);
    fill_random(2);
    run_job(2, 0, 0, -1);

    fill_random(1);
    run_job(1, 0, 2, -1);

    for (int j = 0; j < 10; j++) begin
      int kl;
      kl = int'($urandom_range(1, 12));
      fill_random(kl);
      run_job(kl, int'($urandom_range(0, 60)), int'($urandom_range(0, 2)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
